// File: rtl/rat_io_hub.sv
// rat_io_hub: port-mapped I/O hub for the RAT MCU bus.
// It provides general output registers, an input read multiplexer, a VGA
// framebuffer write port with optional X auto-increment, and a maskable
// edge-triggered interrupt controller that drives the MCU INTERRUPT pulse.
module rat_io_hub #(
  parameter int         NUM_OUT  = 4,
  parameter logic [7:0] OUT_BASE = 8'h40,
  parameter int         NUM_IN   = 2,
  parameter logic [7:0] IN_BASE  = 8'h20,
  parameter int         FB_AW    = 13,
  parameter int         FB_XW    = 7,
  parameter int         NUM_IRQ  = 4,
  parameter logic [7:0] VGA_BASE = 8'h90,
  parameter logic [7:0] IRQ_BASE = 8'hF0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic [7:0]             PORT_ID,
  input  logic [7:0]             OUT_PORT,
  input  logic                   IO_STRB,
  output logic [7:0]             IN_PORT,
  input  logic [NUM_IN*8-1:0]    IN_DATA,
  output logic [NUM_OUT*8-1:0]   OUT_DATA,
  output logic [FB_AW-1:0]       FB_WA,
  output logic [7:0]             FB_WD,
  output logic                   FB_WE,
  input  logic [7:0]             FB_RD,
  input  logic [NUM_IRQ-1:0]     IRQ_SRC,
  output logic                   INTERRUPT
);

  localparam int YW = FB_AW - FB_XW;

  // Half-open ranges [a, a+an) and [b, b+bn) intersect.
  function automatic bit ovl(int a, int an, int b, int bn);
    return (a < b + bn) && (b < a + an);
  endfunction

  localparam int OB = int'(OUT_BASE);
  localparam int IB = int'(IN_BASE);
  localparam int VB = int'(VGA_BASE);
  localparam int QB = int'(IRQ_BASE);

  localparam bit RANGE_OVERLAP =
    ovl(OB, NUM_OUT, IB, NUM_IN) || ovl(OB, NUM_OUT, VB, 5) ||
    ovl(OB, NUM_OUT, QB, 3)      || ovl(IB, NUM_IN, VB, 5)   ||
    ovl(IB, NUM_IN, QB, 3)       || ovl(VB, 5, QB, 3);

  localparam bit RANGE_WRAP =
    (OB + NUM_OUT > 256) || (IB + NUM_IN > 256) || (VB + 5 > 256) || (QB + 3 > 256);

  localparam bit BAD_PARAM =
    (NUM_OUT < 1) || (NUM_OUT > 16) || (NUM_IN < 1) || (NUM_IN > 16) ||
    (NUM_IRQ < 1) || (NUM_IRQ > 8)  || (FB_XW < 1)  || (FB_XW > 8)   ||
    (YW < 1)      || (YW > 8);

  // Refuse to elaborate a map where two devices would answer the same ID.
  if (RANGE_OVERLAP || RANGE_WRAP) begin : g_map_err
    $error("rat_io_hub: port ranges overlap or exceed 8'hFF");
  end
  if (BAD_PARAM) begin : g_param_err
    $error("rat_io_hub: parameter out of supported range");
  end

  localparam logic [FB_XW-1:0] X_ONE = 1;

  // Register-port decode, qualified by the write strobe
  logic wr_haddr, wr_laddr, wr_color, wr_ctrl, wr_mask, wr_ack;
  assign wr_haddr = IO_STRB && (PORT_ID == VGA_BASE);
  assign wr_laddr = IO_STRB && (PORT_ID == VGA_BASE + 8'd1);
  assign wr_color = IO_STRB && (PORT_ID == VGA_BASE + 8'd2);
  assign wr_ctrl  = IO_STRB && (PORT_ID == VGA_BASE + 8'd4);
  assign wr_mask  = IO_STRB && (PORT_ID == IRQ_BASE + 8'd1);
  assign wr_ack   = IO_STRB && (PORT_ID == IRQ_BASE + 8'd2);

  logic [FB_XW-1:0]   x;
  logic [YW-1:0]      y;
  logic               auto_inc;
  logic [NUM_IRQ-1:0] prev, pending, mask, rise;
  logic               req, req_q;

  assign FB_WA = {y, x};
  assign rise  = IRQ_SRC & ~prev;
  assign req   = |(pending & mask);

  // Output register lanes: each lane loads only on a write to its own ID
  always_ff @(posedge CLK) begin
    if (RESET) begin
      OUT_DATA <= '0;
    end else begin
      for (int i = 0; i < NUM_OUT; i++) begin
        if (IO_STRB && (PORT_ID == 8'(OB + i)))
          OUT_DATA[8*i +: 8] <= OUT_PORT;
      end
    end
  end

  // Read multiplexer, combinational and independent of the strobe
  always_comb begin
    IN_PORT = 8'h00;
    for (int i = 0; i < NUM_IN; i++) begin
      if (PORT_ID == 8'(IB + i)) IN_PORT = IN_DATA[8*i +: 8];
    end
    if (PORT_ID == VGA_BASE + 8'd3) IN_PORT = FB_RD;
    if (PORT_ID == VGA_BASE + 8'd4) IN_PORT = {7'b0, auto_inc};
    if (PORT_ID == IRQ_BASE) begin
      IN_PORT = 8'h00;
      IN_PORT[NUM_IRQ-1:0] = pending;
    end
    if (PORT_ID == IRQ_BASE + 8'd1) begin
      IN_PORT = 8'h00;
      IN_PORT[NUM_IRQ-1:0] = mask;
    end
  end

  // Framebuffer port: explicit address writes beat the post-write X increment,
  // which is applied at the end of each FB_WE cycle using the current auto_inc
  always_ff @(posedge CLK) begin
    if (RESET) begin
      x        <= '0;
      y        <= '0;
      auto_inc <= 1'b0;
      FB_WD    <= 8'h00;
      FB_WE    <= 1'b0;
    end else begin
      FB_WE <= wr_color;
      if (wr_color) FB_WD <= OUT_PORT;
      if (wr_laddr)                x <= OUT_PORT[FB_XW-1:0];
      else if (FB_WE && auto_inc)  x <= x + X_ONE;
      if (wr_haddr) y <= OUT_PORT[YW-1:0];
      if (wr_ctrl)  auto_inc <= OUT_PORT[0];
    end
  end

  // Interrupt controller: edge capture wins over a same-cycle ACK, and the
  // pulse fires on every 0->1 transition of the masked request
  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev      <= IRQ_SRC;
      pending   <= '0;
      mask      <= '0;
      req_q     <= 1'b0;
      INTERRUPT <= 1'b0;
    end else begin
      prev      <= IRQ_SRC;
      pending   <= (pending & ~(wr_ack ? OUT_PORT[NUM_IRQ-1:0] : '0)) | rise;
      if (wr_mask) mask <= OUT_PORT[NUM_IRQ-1:0];
      req_q     <= req;
      INTERRUPT <= req & ~req_q;
    end
  end

endmodule

// File: doc/rat_io_hub.md
# rat_io_hub

Parametrised port-mapped I/O hub between the RAT MCU port bus and the board peripherals. It provides:
- N general output registers and an M-lane input multiplexer.
- A VGA framebuffer write port with single-cycle write strobes and optional X auto-increment.
- A maskable edge-triggered interrupt controller that produces the MCU's single-cycle INTERRUPT pulse.

It replaces the fixed per-design port decode in the top-level wrapper.

## Interface
Parameters:
- NUM_OUT, 4: output registers, 1..16, mapped at OUT_BASE+i.
- OUT_BASE, 8'h40: first output port ID.
- NUM_IN, 2: input lanes, 1..16, mapped at IN_BASE+i.
- IN_BASE, 8'h20: first input port ID.
- FB_AW, 13: framebuffer address width.
- FB_XW, 7: X field width; Y field is FB_AW-FB_XW bits.
- NUM_IRQ, 4: interrupt sources, 1..8.
- VGA_BASE, 8'h90: HADDR=+0, LADDR=+1, COLOR=+2 (write); READ=+3 (read); CTRL=+4 (write/read).
- IRQ_BASE, 8'hF0: STATUS=+0 (read); MASK=+1 (write/read); ACK=+2 (write).
- The elaboration must fail if any two port ranges overlap.

Ports:
- CLK, in, 1: single clock. All state changes on the rising edge.
- RESET, in, 1: synchronous, active-high.
- PORT_ID, in, 8: MCU port ID.
- OUT_PORT, in, 8: MCU write data.
- IO_STRB, in, 1: MCU write strobe, one cycle per write.
- IN_PORT, out, 8: read data to the MCU. Combinational.
- IN_DATA, in, NUM_IN*8: input lanes. Lane i is IN_DATA[8i+7:8i].
- OUT_DATA, out, NUM_OUT*8: output registers, same packing as IN_DATA.
- FB_WA, out, FB_AW: framebuffer address, {Y,X}.
- FB_WD, out, 8: framebuffer write pixel.
- FB_WE, out, 1: framebuffer write enable.
- FB_RD, in, 8: framebuffer read pixel.
- IRQ_SRC, in, NUM_IRQ: interrupt sources, synchronous to CLK.
- INTERRUPT, out, 1: interrupt pulse to the MCU.

## Operation
- **Writes.** A write is any cycle with IO_STRB=1. A PORT_ID outside every range is ignored.
- **Output registers.**
  - A write to OUT_BASE+i loads OUT_DATA lane i from OUT_PORT.
  - Other lanes hold their value.
- **Read multiplexer.** IN_PORT is selected by PORT_ID, independent of IO_STRB:
  - IN_BASE+i returns IN_DATA lane i.
  - VGA READ returns FB_RD.
  - VGA CTRL returns {7'b0, auto_inc}.
  - IRQ STATUS returns the pending bits, zero-extended.
  - IRQ MASK returns the mask, zero-extended.
  - Any other ID returns 8'h00.
- **VGA address registers.**
  - HADDR loads FB_WA Y field from OUT_PORT[FB_AW-FB_XW-1:0].
  - LADDR loads FB_WA X field from OUT_PORT[FB_XW-1:0].
  - CTRL loads auto_inc from OUT_PORT[0].
- **VGA COLOR write.**
  - FB_WD latches OUT_PORT.
  - FB_WE is asserted for exactly the following cycle, with FB_WA unchanged during that cycle.
  - At the end of the FB_WE cycle, if auto_inc=1, X increments modulo 2^FB_XW. X wraps from all-ones to 0 and Y never changes.
- **Interrupt edge detection.**
  - prev registers IRQ_SRC.
  - Bit i is a rising edge when IRQ_SRC[i] & ~prev[i].
  - A rising edge sets pending[i].
- **Interrupt acknowledge.** A write to ACK clears every pending[i] whose OUT_PORT[i]=1.
- **Interrupt mask.** A write to MASK loads the mask from OUT_PORT[NUM_IRQ-1:0].
- **Interrupt request.**
  - req = |(pending & mask), registered as req_q.
  - INTERRUPT = req & ~req_q, registered, so it is a single-cycle pulse on each 0→1 transition of req.
  - Enabling the mask bit of an already-pending source also produces a pulse.
- **Simultaneous events.**
  - Edge and ACK on the same bit in the same cycle: the set wins, and pending stays 1.
  - HADDR or LADDR write during an FB_WE cycle: the explicit write wins for that field, and no increment is applied to it.
  - COLOR write during an FB_WE cycle:
    - Data and address are updated at that edge, with the increment applied if enabled.
    - FB_WE stays high one more cycle with the new data at the new address.

## Timing
- **Reset values.** On RESET:
  - OUT_DATA=0, FB_WA=0, FB_WD=0, FB_WE=0.
  - auto_inc=0, mask=0, pending=0, req_q=0, INTERRUPT=0.
  - prev is loaded with IRQ_SRC, so a source held high through reset causes no edge.
- **Reset mid-operation.** RESET overrides any simultaneous write. An FB_WE in progress is dropped on the next edge.
- **Output register latency.** Strobe in cycle t, new value visible from cycle t+1.
- **Read latency.** 0 cycles (combinational).
- **COLOR write timeline.**
  - Strobe in cycle t.
  - FB_WE=1 and FB_WD valid in cycle t+1.
  - Incremented FB_WA from cycle t+2.
- **Interrupt latency.**
  - IRQ_SRC rises in cycle t, and prev updates at the end of t.
  - pending[i]=1 from t+1.
  - INTERRUPT=1 in cycle t+2 only, when the source is unmasked.

## Test plan
- **Output register write.** Reset, then write 8'hA5 to 8'h41 → lane 1 = A5 from the next cycle, other lanes 0. Reading 8'h20 with IN_DATA lane 0 = 3C gives IN_PORT=3C. Reading 8'h55 gives 00.
- **VGA auto-increment and wrap.** CTRL=1, HADDR=5, LADDR=7F, COLOR=E0, then COLOR=1C:
  - First write: FB_WE high one cycle at FB_WA={5,7F} with FB_WD=E0.
  - Second write: at {5,00} with FB_WD=1C.
  - No cycle with FB_WE high and FB_WA changing.
- **VGA without auto-increment.** CTRL=0, two COLOR writes → both at the same FB_WA. FB_WE is low between the two strobes.
- **Masked then enabled interrupt.** Mask=0, pulse IRQ_SRC[2] → STATUS=04 and INTERRUPT stays 0. Write MASK=04 → exactly one INTERRUPT pulse. ACK=04 → STATUS=00.
- **Edge and ACK collide.** IRQ_SRC[0] edge in the same cycle as ACK=01 → pending[0] remains 1. A second edge on [1] while [0] is pending and unmasked → no new INTERRUPT pulse.
- **Reset mid-operation.** RESET in the cycle after a COLOR strobe with IRQ_SRC held high:
  - FB_WE is 0 after reset.
  - All outputs return to reset values.
  - No INTERRUPT pulse after release.
